// File: rtl/loopback_fifo_nch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | loopback_fifo_nch: per-channel elastic byte FIFOs echoing OUT to IN.      |
// | Optional per-channel fill level via LOOPBACK_LEVEL_EN.  Revision 1.0      |
// +--------------------------------------------------------------------------+
module loopback_fifo_nch #(
   parameter int CHANNELS = 7,
   parameter int DEPTH    = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [8*CHANNELS-1:0] out_data_i,
   input  logic [CHANNELS-1:0]   out_valid_i,
   output logic [CHANNELS-1:0]   out_ready_o,
   output logic [8*CHANNELS-1:0] in_data_o,
   output logic [CHANNELS-1:0]   in_valid_o,
   input  logic [CHANNELS-1:0]   in_ready_i
`ifdef LOOPBACK_LEVEL_EN
   ,
   output logic [CHANNELS*($clog2(DEPTH)+1)-1:0] level_o
`endif
);

   localparam int              PTR_W      = $clog2(DEPTH);
   localparam int              CNT_W      = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
      logic [7:0]       mem_q [DEPTH];
      logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
      logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
      logic [CNT_W-1:0] count_q, count_d;
      logic             out_ready_q, out_ready_d;
      logic             in_valid_q, in_valid_d;
      logic [7:0]       rd_data_q, rd_data_d;
      logic [7:0]       wr_byte;
      logic             push, pop;

      always_comb begin
         wr_byte  = out_data_i[8*k +: 8];
         push     = out_valid_i[k] & out_ready_q;
         pop      = in_valid_q & in_ready_i[k];
         wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
         rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase

         out_ready_d = (count_d < FULL_COUNT);
         in_valid_d  = (count_d != '0);

         // The slot under the next read pointer is only unwritten when the
         // FIFO drains to empty this cycle, so forward the incoming byte then.
         if (push && (wr_ptr_q == rd_ptr_d)) begin
            rd_data_d = wr_byte;
         end else begin
            rd_data_d = mem_q[rd_ptr_d];
         end
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_ready_q <= 1'b0;
            in_valid_q  <= 1'b0;
            rd_data_q   <= '0;
         end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_ready_q <= out_ready_d;
            in_valid_q  <= in_valid_d;
            rd_data_q   <= rd_data_d;
         end
      end

      always_ff @(posedge clk_i) begin
         if (push && !rst_i) begin
            mem_q[wr_ptr_q] <= wr_byte;
         end
      end

      assign out_ready_o[k]      = out_ready_q;
      assign in_valid_o[k]       = in_valid_q;
      assign in_data_o[8*k +: 8] = rd_data_q;
`ifdef LOOPBACK_LEVEL_EN
      assign level_o[CNT_W*k +: CNT_W] = count_q;
`endif
   end

endmodule
`default_nettype wire

// File: tb/tb_loopback_fifo_nch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_loopback_fifo_nch: scoreboard bench for loopback_fifo_nch.             |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_loopback_fifo_nch;

   localparam int CH    = 7;
   localparam int DEPTH = 16;
   localparam int CW    = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic [8*CH-1:0] out_data;
   logic [CH-1:0]   out_valid;
   logic [CH-1:0]   out_ready;
   logic [8*CH-1:0] in_data;
   logic [CH-1:0]   in_valid;
   logic [CH-1:0]   in_ready;
`ifdef LOOPBACK_LEVEL_EN
   logic [CH*CW-1:0] level;
`endif

   int         errors = 0;
   int         checks = 0;
   logic [7:0] sb [CH][$];
   logic [7:0] mon_exp;

   always #5 clk = ~clk;

   loopback_fifo_nch #(
      .CHANNELS (CH),
      .DEPTH    (DEPTH)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .out_data_i  (out_data),
      .out_valid_i (out_valid),
      .out_ready_o (out_ready),
      .in_data_o   (in_data),
      .in_valid_o  (in_valid),
      .in_ready_i  (in_ready)
`ifdef LOOPBACK_LEVEL_EN
      ,
      .level_o     (level)
`endif
   );

   // Scoreboard: accepted OUT bytes are queued per channel, IN bytes popped.
   always @(negedge clk) begin
      if (rst) begin
         for (int k = 0; k < CH; k++) sb[k].delete();
      end else begin
         for (int k = 0; k < CH; k++) begin
            if (in_valid[k] && in_ready[k]) begin
               checks++;
               if (sb[k].size() == 0) begin
                  errors++;
                  $display("FAIL sb_ch%0d: got %02h, required no output (nothing pending)", k, in_data[8*k +: 8]);
               end else begin
                  mon_exp = sb[k].pop_front();
                  if (in_data[8*k +: 8] !== mon_exp) begin
                     errors++;
                     $display("FAIL sb_ch%0d: got %02h, required %02h", k, in_data[8*k +: 8], mon_exp);
                  end
               end
            end
            if (out_valid[k] && out_ready[k]) sb[k].push_back(out_data[8*k +: 8]);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit sb_empty();
      for (int k = 0; k < CH; k++) if (sb[k].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic drain(input string name);
      int n = 0;
      out_valid = '0;
      in_ready  = '1;
      while (n < 200 && !(sb_empty() && in_valid == '0)) begin
         tick();
         n++;
      end
      checks++;
      if (!(sb_empty() && in_valid == '0)) begin
         errors++;
         $display("FAIL %s_drain: got in_valid=%b pending=%0d, required empty", name, in_valid, sb_empty() ? 0 : 1);
      end
   endtask

   task automatic push_byte(input int ch, input logic [7:0] b);
      out_valid[ch]         = 1'b1;
      out_data[8*ch +: 8]   = b;
      tick();
      out_valid[ch]         = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; out_valid = '0; in_ready = '0; out_data = '0;
      repeat (3) tick();
      checks++; if (out_ready !== '0) begin errors++; $display("FAIL rst_out_ready: got %b, required 0", out_ready); end
      checks++; if (in_valid !== '0) begin errors++; $display("FAIL rst_in_valid: got %b, required 0", in_valid); end
      checks++; if (in_data !== '0) begin errors++; $display("FAIL rst_in_data: got %h, required 0", in_data); end
`ifdef LOOPBACK_LEVEL_EN
      checks++; if (level !== '0) begin errors++; $display("FAIL rst_level: got %h, required 0", level); end
`endif
      rst = 1'b0;
      tick();
      checks++; if (out_ready !== 7'h7f) begin errors++; $display("FAIL post_rst_out_ready: got %b, required 1111111", out_ready); end
      checks++; if (in_valid !== '0) begin errors++; $display("FAIL post_rst_in_valid: got %b, required 0", in_valid); end
   endtask

   task automatic test_ch0_order();
      in_ready = '1;
      for (int i = 1; i <= 7; i++) begin
         out_valid[0]  = 1'b1;
         out_data[7:0] = 8'(i);
         tick();
         if (i == 1) begin
            checks++;
            if (in_valid[0] !== 1'b1 || in_data[7:0] !== 8'h01) begin
               errors++;
               $display("FAIL ch0_latency: got valid=%b data=%02h, required valid=1 data=01", in_valid[0], in_data[7:0]);
            end
         end
         checks++;
         if (in_valid[6:1] !== 6'b0) begin
            errors++;
            $display("FAIL ch0_other_idle: got %b, required 000000", in_valid[6:1]);
         end
      end
      drain("ch0_order");
   endtask

   task automatic test_concurrent();
      int  i1 = 0;
      int  i6 = 0;
      int  guard = 0;
      bit  acc1, acc6;
      in_ready = '1;
      while ((i1 < 7 || i6 < 7) && guard < 300) begin
         out_valid[1]   = (i1 < 7) && ($urandom_range(0, 1) == 1);
         out_data[15:8] = 8'(8'h81 + i1);
         out_valid[6]   = (i6 < 7) && ($urandom_range(0, 1) == 1);
         out_data[55:48] = 8'(8'hD1 + i6);
         in_ready[1]    = ($urandom_range(0, 1) == 1);
         acc1 = out_valid[1] && out_ready[1];
         acc6 = out_valid[6] && out_ready[6];
         tick();
         if (acc1) i1++;
         if (acc6) i6++;
         guard++;
         checks++;
         if ({in_valid[5:2], in_valid[0]} !== 5'b0) begin
            errors++;
            $display("FAIL conc_crosstalk: got in_valid=%b, required ch0/2-5 idle", in_valid);
         end
      end
      checks++;
      if (i1 != 7 || i6 != 7) begin
         errors++;
         $display("FAIL conc_accept: got ch1=%0d ch6=%0d, required 7 each", i1, i6);
      end
      drain("concurrent");
   endtask

   task automatic test_full();
      int acc = 0;
      bit ok;
      in_ready = '1; in_ready[0] = 1'b0; out_valid = '0;
      for (int c = 0; c < 21; c++) begin
         out_valid[0]  = 1'b1;
         out_data[7:0] = 8'(8'hA0 + acc);
         ok = out_ready[0];
         tick();
         if (ok) begin
            acc++;
            if (acc == DEPTH) begin
               checks++;
               if (out_ready[0] !== 1'b0) begin errors++; $display("FAIL full_ready_drop: got %b, required 0", out_ready[0]); end
            end
         end
      end
      checks++; if (acc != DEPTH) begin errors++; $display("FAIL full_accepted: got %0d, required %0d", acc, DEPTH); end
      checks++; if (out_ready[0] !== 1'b0) begin errors++; $display("FAIL full_ready_hold: got %b, required 0", out_ready[0]); end
`ifdef LOOPBACK_LEVEL_EN
      checks++; if (level[4:0] !== 5'd16) begin errors++; $display("FAIL full_level: got %0d, required 16", level[4:0]); end
`endif
      out_valid[0] = 1'b0;
      in_ready[0]  = 1'b1;
      tick();
      checks++; if (out_ready[0] !== 1'b1) begin errors++; $display("FAIL full_ready_return: got %b, required 1", out_ready[0]); end
      drain("full");
   endtask

   task automatic test_stall();
      in_ready = '1; in_ready[2] = 1'b0;
      push_byte(2, 8'h55);
      push_byte(2, 8'h66);
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if (in_valid[2] !== 1'b1 || in_data[23:16] !== 8'h55) begin
            errors++;
            $display("FAIL stall_hold: got valid=%b data=%02h, required valid=1 data=55", in_valid[2], in_data[23:16]);
         end
`ifdef LOOPBACK_LEVEL_EN
         checks++;
         if (level[14:10] !== 5'd2) begin errors++; $display("FAIL stall_level: got %0d, required 2", level[14:10]); end
`endif
      end
      drain("stall");
   endtask

   task automatic test_back_to_back();
      in_ready = '1; in_ready[3] = 1'b0;
      for (int i = 0; i < 8; i++) push_byte(3, 8'(8'h10 + i));
      in_ready[3] = 1'b1;
      for (int c = 0; c < 32; c++) begin
         out_valid[3]    = 1'b1;
         out_data[31:24] = 8'(8'h18 + c);
         tick();
         checks++;
         if (out_ready[3] !== 1'b1 || in_valid[3] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_flow: got ready=%b valid=%b, required 1/1", out_ready[3], in_valid[3]);
         end
`ifdef LOOPBACK_LEVEL_EN
         checks++;
         if (level[19:15] !== 5'd8) begin errors++; $display("FAIL b2b_level: got %0d, required 8", level[19:15]); end
`endif
      end
      drain("b2b");
   endtask

   task automatic test_reset_mid();
      in_ready = '1; in_ready[0] = 1'b0;
      for (int i = 0; i < 5; i++) push_byte(0, 8'(8'hE1 + i));
`ifdef LOOPBACK_LEVEL_EN
      checks++; if (level[4:0] !== 5'd5) begin errors++; $display("FAIL mid_level: got %0d, required 5", level[4:0]); end
`endif
      rst = 1'b1;
      out_valid[0] = 1'b1; out_data[7:0] = 8'hEE; in_ready[0] = 1'b1;
      tick();
      checks++; if (in_valid !== '0) begin errors++; $display("FAIL mid_in_valid: got %b, required 0", in_valid); end
      checks++; if (out_ready !== '0) begin errors++; $display("FAIL mid_out_ready: got %b, required 0", out_ready); end
      rst = 1'b0; out_valid = '0;
      tick();
      checks++; if (out_ready !== 7'h7f) begin errors++; $display("FAIL mid_release_ready: got %b, required 1111111", out_ready); end
      checks++; if (in_valid !== '0) begin errors++; $display("FAIL mid_release_valid: got %b, required 0", in_valid); end
      push_byte(0, 8'h71);
      push_byte(0, 8'h72);
      drain("reset_mid");
   endtask

   initial begin
      test_reset();
      test_ch0_order();
      test_concurrent();
      test_full();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      repeat (2) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
